// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared definitions for the Wishbone command master: FSM state
//             encoding, response status codes and default bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Default bus geometry
    localparam int WB_ADDR_WIDTH_DEF = 32;
    localparam int WB_DATA_WIDTH_DEF = 32;
    localparam int WB_TIMEOUT_DEF    = 1024;

    // Response status codes
    localparam logic [1:0] WB_ST_OK      = 2'b00;
    localparam logic [1:0] WB_ST_ERR     = 2'b01;
    localparam logic [1:0] WB_ST_TIMEOUT = 2'b10;

    // Master FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_cmd_master
//  Purpose  : Wishbone classic single-access initiator. Each command accepted
//             on the cmd_* valid/ready stream becomes exactly one Wishbone
//             read or write cycle; the outcome is returned on the rsp_*
//             valid/ready stream. One command outstanding at a time.
//  Ports    : wb_clk_i/wb_rst_i      clock, async active-high reset
//             cmd_*                  command stream (we/sel/adr/dat)
//             rsp_*                  response stream (read data, status)
//             wb_*                   Wishbone classic initiator interface
//  Options  : WB_TIMEOUT_EN - when defined, a bus cycle with no ack/err is
//             aborted after C_TIMEOUT cycles with status TIMEOUT.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int C_WB_ADDR_WIDTH = WB_ADDR_WIDTH_DEF,
    parameter int C_WB_DATA_WIDTH = WB_DATA_WIDTH_DEF,
    parameter int C_TIMEOUT       = WB_TIMEOUT_DEF
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    // command stream
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         cmd_we_i,
    input  logic [C_WB_DATA_WIDTH/8-1:0] cmd_sel_i,
    input  logic [C_WB_ADDR_WIDTH-1:0]   cmd_adr_i,
    input  logic [C_WB_DATA_WIDTH-1:0]   cmd_dat_i,
    // response stream
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [C_WB_DATA_WIDTH-1:0]   rsp_dat_o,
    output logic [1:0]                   rsp_status_o,
    // Wishbone initiator
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic                         wb_we_o,
    output logic [C_WB_DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [C_WB_ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [C_WB_DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [C_WB_DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                         wb_ack_i,
    input  logic                         wb_err_i
);

    // Elaboration-time guard on the timeout range
    if (C_TIMEOUT < 1) begin : g_timeout_range_check
        $error("wb_cmd_master: C_TIMEOUT must be >= 1");
    end

    wb_state_t                  r_state;
    wb_state_t                  w_state_nxt;
    logic                       w_accept;
    logic                       w_end;
    logic [1:0]                 w_end_status;
    logic [C_WB_DATA_WIDTH-1:0] w_end_dat;
    logic                       w_tmo_hit;

    // cmd_ready_o is high exactly while in IDLE
    assign w_accept = (r_state == IDLE) && cmd_valid_i;

`ifdef WB_TIMEOUT_EN
    localparam int TMO_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;

    // Held at zero outside BUS, so it is zero on the first stb cycle and
    // reaches C_TIMEOUT-1 on the C_TIMEOUT-th stb cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state != BUS) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(C_TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and bus-termination decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_end        = 1'b0;
        w_end_status = WB_ST_OK;
        w_end_dat    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                // err beats ack; either beats a timeout on the same cycle
                if (wb_err_i) begin
                    w_end        = 1'b1;
                    w_end_status = WB_ST_ERR;
                end else if (wb_ack_i) begin
                    w_end     = 1'b1;
                    w_end_dat = wb_we_o ? '0 : wb_dat_i;
                end else if (w_tmo_hit) begin
                    w_end        = 1'b1;
                    w_end_status = WB_ST_TIMEOUT;
                end
                if (w_end) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs: the strobes are decoded from the next state so
    // they line up with r_state after each edge.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= WB_ST_OK;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
        end else begin
            cmd_ready_o <= (w_state_nxt == IDLE);
            rsp_valid_o <= (w_state_nxt == RESP);
            wb_cyc_o    <= (w_state_nxt == BUS);
            wb_stb_o    <= (w_state_nxt == BUS);
            if (w_accept) begin
                wb_we_o  <= cmd_we_i;
                wb_sel_o <= cmd_sel_i;
                wb_adr_o <= cmd_adr_i;
                wb_dat_o <= cmd_dat_i;
            end
            if (w_end) begin
                rsp_dat_o    <= w_end_dat;
                rsp_status_o <= w_end_status;
            end
        end
    end

endmodule : wb_cmd_master
`default_nettype wire
